// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream and emits a
// one-cycle word_valid pulse together with the completed word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reload,
  input  logic        byte_accept,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [IDX_W-1:0] byte_idx;
  logic [23:0]      lanes;

  // The byte currently presented would complete the word.
  assign last_byte = (byte_idx == IDX_W'(WORD_BYTES - 1));

  // Place each accepted byte in its lane; the top lane completes the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx   <= '0;
      lanes      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (reload) begin
        byte_idx <= '0;
        lanes    <= '0;
      end else if (byte_accept) begin
        byte_idx <= byte_idx + 1'b1;
        case (byte_idx)
          2'd0:    lanes[7:0]   <= byte_data;
          2'd1:    lanes[15:8]  <= byte_data;
          2'd2:    lanes[23:16] <= byte_data;
          default: begin
            word       <= {byte_data, lanes};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length header and a word stream, writes the
// instruction memory and holds the core in reset until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state;
  state_t      next_state;
  logic [7:0]  len_lo;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [15:0] hdr_count;
  logic        accept;
  logic        data_accept;
  logic        word_done;
  logic        last_word;
  logic        last_byte;
  logic        word_valid;
  logic [31:0] word;

  assign rx_ready    = reset_n && !reload &&
                       ((state == S_LEN0) || (state == S_LEN1) || (state == S_DATA));
  assign accept      = rx_valid && rx_ready;
  assign data_accept = accept && (state == S_DATA);
  assign word_done   = data_accept && last_byte;
  assign last_word   = (word_idx == count - 16'd1);
  assign hdr_count   = {rx_data, len_lo};

  byte_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .reload      (reload),
    .byte_accept (data_accept),
    .byte_data   (rx_data),
    .last_byte   (last_byte),
    .word_valid  (word_valid),
    .word        (word)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_LEN0;
    else          state <= next_state;
  end

  // Next-state decode; reload overrides every other transition.
  always_comb begin
    next_state = state;
    if (reload) begin
      next_state = S_LEN0;
    end else begin
      case (state)
        S_LEN0: if (accept) next_state = S_LEN1;
        S_LEN1: begin
          if (accept) begin
            if (hdr_count == 16'd0)      next_state = S_DONE;
            else if (hdr_count > DEPTH_W) next_state = S_ERR;
            else                          next_state = S_DATA;
          end
        end
        S_DATA: if (word_done && last_word) next_state = S_DONE;
        default: next_state = state;
      endcase
    end
  end

  // Header capture, word counter and registered write address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_lo    <= '0;
      count     <= '0;
      word_idx  <= '0;
      imem_addr <= '0;
    end else if (reload) begin
      word_idx <= '0;
    end else begin
      if (accept && (state == S_LEN0)) len_lo <= rx_data;
      if (accept && (state == S_LEN1)) begin
        count    <= hdr_count;
        word_idx <= '0;
      end
      if (word_done) begin
        imem_addr <= {14'd0, word_idx, 2'b00};
        if (!last_word) word_idx <= word_idx + 16'd1;
      end
    end
  end

  // Release the core only after a full cycle spent in S_DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_reset <= 1'b1;
    else          cpu_reset <= reload || (state != S_DONE);
  end

  assign imem_we    = word_valid;
  assign imem_wdata = word;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the
// stimulus and popped by a monitor whenever imem_we is seen.
module tb_imem_loader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int          vectors;
  int          miscompares;
  int          write_count;
  logic [63:0] exp_q[$];
  logic [7:0]  frame[$];

  imem_loader #(.DEPTH(256)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Send every byte of 'frame'; caller is at a negedge, returns at a negedge.
  task automatic applyStimulus(input int max_gap);
    foreach (frame[i]) begin
      int n;
      if (max_gap > 0) begin
        int gap;
        gap = $urandom_range(0, max_gap);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      rx_data  = frame[i];
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!rx_ready) checkOutput("rx_ready_timeout", 32'(rx_ready), 32'd1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    #1;
    checkOutput("rx_ready_in_reload", 32'(rx_ready), 32'd0);
    @(negedge clk);
    reload   = 1'b0;
    rx_valid = 1'b0;
    #1;
    checkOutput("cpu_reset_after_reload", 32'(cpu_reset), 32'd1);
    checkOutput("done_after_reload", 32'(done), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      write_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write_addr", imem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        checkOutput("write_addr", imem_addr, e[63:32]);
        checkOutput("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wc;
    vectors     = 0;
    miscompares = 0;
    write_count = 0;
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("reset_imem_we", 32'(imem_we), 32'd0);
    checkOutput("reset_imem_addr", imem_addr, 32'd0);
    checkOutput("reset_imem_wdata", imem_wdata, 32'd0);
    checkOutput("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_rx_ready", 32'(rx_ready), 32'd1);

    // Basic load, N=2, no gaps.
    $display("[TB] basic load");
    pushExpect(32'h0, 32'h1234_5678);
    pushExpect(32'h4, 32'h9ABC_DEF0);
    frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A};
    applyStimulus(0);
    checkOutput("basic_we_with_done", 32'(imem_we), 32'd1);
    checkOutput("basic_done", 32'(done), 32'd1);
    checkOutput("basic_cpu_reset_held", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    checkOutput("basic_cpu_reset_released", 32'(cpu_reset), 32'd0);
    checkOutput("basic_we_single", 32'(imem_we), 32'd0);
    checkOutput("basic_addr_hold", imem_addr, 32'h4);
    checkOutput("basic_wdata_hold", imem_wdata, 32'h9ABC_DEF0);
    checkOutput("basic_rx_ready_done", 32'(rx_ready), 32'd0);
    pulseReload();

    // Empty image.
    $display("[TB] empty image");
    frame = '{8'h00, 8'h00};
    applyStimulus(0);
    checkOutput("empty_done", 32'(done), 32'd1);
    checkOutput("empty_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("empty_error", 32'(error), 32'd0);
    @(negedge clk);
    checkOutput("empty_cpu_reset", 32'(cpu_reset), 32'd0);
    pulseReload();

    // Oversize header 0x0101.
    $display("[TB] oversize");
    frame = '{8'h01, 8'h01};
    applyStimulus(0);
    checkOutput("over_error", 32'(error), 32'd1);
    checkOutput("over_done", 32'(done), 32'd0);
    checkOutput("over_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("over_cpu_reset", 32'(cpu_reset), 32'd1);
    pulseReload();

    // Gapped handshake, N=3.
    $display("[TB] gapped load");
    wc = write_count;
    pushExpect(32'h0, 32'hDEAD_BEEF);
    pushExpect(32'h4, 32'h0123_4567);
    pushExpect(32'h8, 32'hCAFE_F00D);
    frame = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01,
              8'h0D, 8'hF0, 8'hFE, 8'hCA};
    applyStimulus(3);
    checkOutput("gap_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("gap_write_count", 32'(write_count - wc), 32'd3);
    pulseReload();

    // Reload after two data bytes of the first word.
    $display("[TB] reload mid-word");
    frame = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    applyStimulus(0);
    rx_data  = 8'hCC;
    rx_valid = 1'b1;
    pulseReload();
    wc = write_count;
    pushExpect(32'h0, 32'h1111_1111);
    frame = '{8'h01, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11};
    applyStimulus(0);
    checkOutput("rl_done", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("rl_write_count", 32'(write_count - wc), 32'd1);
    pulseReload();

    // Asynchronous reset in the middle of a word.
    $display("[TB] async reset mid-frame");
    frame = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
    applyStimulus(0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("areset_imem_we", 32'(imem_we), 32'd0);
    checkOutput("areset_imem_addr", imem_addr, 32'd0);
    checkOutput("areset_imem_wdata", imem_wdata, 32'd0);
    checkOutput("areset_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("areset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pushExpect(32'h0, 32'h1122_3344);
    frame = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    applyStimulus(0);
    checkOutput("post_reset_done", 32'(done), 32'd1);

    repeat (3) @(negedge clk);
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
